// File: rtl/hc595_pkg.sv
// Shared widths, field positions and receiver state encoding for the
// dual-74HC595 receive-side link model.
package hc595_pkg;

    localparam int FRAME_W     = 16;
    localparam int SEL_W       = 6;
    localparam int SEG_W       = 8;
    localparam int SEL_MSB_POS = 13;
    localparam int SEG_MSB_POS = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        OVER  = 2'd2
    } rx_state_e;

endpackage

// File: rtl/hc595_rx_if.sv
// Link lines from the 74HC595 driver plus the recovered frame outputs.
interface hc595_rx_if;
    import hc595_pkg::*;

    logic               shcp;
    logic               stcp;
    logic               ds;
    logic               oe;
    logic [FRAME_W-1:0] word;
    logic [SEL_W-1:0]   sel;
    logic [SEG_W-1:0]   seg;
    logic               out_en;
    logic               frame_valid;
    logic               frame_err;
    logic               link_lost;

    modport master (
        output shcp, stcp, ds, oe,
        input  word, sel, seg, out_en, frame_valid, frame_err, link_lost
    );

    modport slave (
        input  shcp, stcp, ds, oe,
        output word, sel, seg, out_en, frame_valid, frame_err, link_lost
    );

endinterface

// File: rtl/hc595_rx_sync_edge.sv
// Multi-flop synchronizer with a history flop and a registered rise pulse.
// sync is taken from the history flop so data lines stay aligned with rise.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic d,
    output logic sync,
    output logic rise
);

    logic [STAGES-1:0] chain;
    logic              hist;
    logic              rise_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            chain  <= '0;
            hist   <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            chain  <= {chain[STAGES-2:0], d};
            hist   <= chain[STAGES-1];
            rise_q <= chain[STAGES-1] & ~hist;
        end
    end

    assign sync = hist;
    assign rise = rise_q;

endmodule

// File: rtl/hc595_rx.sv
// Receive side of the dual-74HC595 display link: deserializes 16-bit frames,
// recovers sel/seg fields, flags framing errors and link loss.
//
// state | meaning
// IDLE  | no shifts since the last latch (cnt = 0)
// SHIFT | 1..16 shifts received
// OVER  | more than 16 shifts; next latch reports an error
module hc595_rx
    import hc595_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1_000_000,
    parameter int CNT_W       = 5
) (
    input logic        sys_clk,
    input logic        sys_rst_n,
    hc595_rx_if.slave  link
);

    localparam int                TCNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0]  FRAME_CNT = CNT_W'(FRAME_W);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYC - 1);

    logic shcp_rise, stcp_rise, ds_s, oe_s;
    logic shcp_sync_unused, stcp_sync_unused, ds_rise_unused, oe_rise_unused;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_shcp (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .d(link.shcp),
        .sync(shcp_sync_unused), .rise(shcp_rise));
    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_stcp (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .d(link.stcp),
        .sync(stcp_sync_unused), .rise(stcp_rise));
    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ds (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .d(link.ds),
        .sync(ds_s), .rise(ds_rise_unused));
    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_oe (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .d(link.oe),
        .sync(oe_s), .rise(oe_rise_unused));

    rx_state_e          state;
    logic [FRAME_W-1:0] sr;
    logic [FRAME_W-1:0] word_q;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_inc;
    logic [TCNT_W-1:0]  tcnt;
    logic               frame_valid_q, frame_err_q, link_lost_q, out_en_q;

    assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state         <= IDLE;
            sr            <= '0;
            word_q        <= '0;
            cnt           <= '0;
            tcnt          <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            link_lost_q   <= 1'b0;
            out_en_q      <= 1'b0;
        end else begin
            out_en_q      <= ~oe_s;
            frame_valid_q <= stcp_rise;
            frame_err_q   <= stcp_rise && !((state == SHIFT) && (cnt == FRAME_CNT));

            // Latch sees the pre-shift register; a coincident shift opens the next frame.
            if (stcp_rise)
                word_q <= sr;
            if (shcp_rise)
                sr <= {ds_s, sr[FRAME_W-1:1]};

            if (stcp_rise) begin
                cnt   <= shcp_rise ? CNT_W'(1) : '0;
                state <= shcp_rise ? SHIFT : IDLE;
            end else if (shcp_rise) begin
                cnt   <= cnt_inc;
                state <= (cnt_inc > FRAME_CNT) ? OVER : SHIFT;
            end

            if (stcp_rise) begin
                tcnt        <= '0;
                link_lost_q <= 1'b0;
            end else if (tcnt == TCNT_LAST) begin
                link_lost_q <= 1'b1;
            end else begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < SEG_W; i++) begin : g_seg
        assign link.seg[i] = word_q[SEG_MSB_POS-i];
    end
    for (genvar i = 0; i < SEL_W; i++) begin : g_sel
        assign link.sel[i] = word_q[SEL_MSB_POS-i];
    end

    assign link.word        = word_q;
    assign link.out_en      = out_en_q;
    assign link.frame_valid = frame_valid_q;
    assign link.frame_err   = frame_err_q;
    assign link.link_lost   = link_lost_q;

endmodule

// File: tb/tb_hc595_rx.sv
// Directed bench for hc595_rx: link stimulus, a bit-history reference model
// compared every cycle, and literal checks of hand-computed frames.
module tb_hc595_rx;

    localparam int SYNC = 2;
    localparam int TMO  = 100;
    localparam int D    = SYNC + 1;
    localparam int HMAX = 4096;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    hc595_rx_if bus();

    hc595_rx #(.SYNC_STAGES(SYNC), .TIMEOUT_CYC(TMO), .CNT_W(5)) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .link     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: inputs as sampled at each clock edge act D edges later.
    int          cyc = 0;
    logic        h_shcp [HMAX];
    logic        h_stcp [HMAX];
    logic        h_ds   [HMAX];
    logic        h_oe   [HMAX];
    bit          rx_bits[$];
    int          since = 0;
    int          last_clear = 0;
    logic [15:0] m_word = '0;
    logic        m_fv = 1'b0, m_err = 1'b0, m_oe_n = 1'b0;
    int          k;
    logic        sh_r, st_r;
    int          fv_seen = 0, err_seen = 0;

    function automatic logic [15:0] last16();
        logic [15:0] w = '0;
        int n = rx_bits.size();
        for (int j = 0; j < 16 && j < n; j++) w[15-j] = rx_bits[n-1-j];
        return w;
    endfunction

    function automatic logic [7:0] seg_of(input logic [15:0] w);
        logic [7:0] s;
        for (int i = 0; i < 8; i++) s[i] = w[7-i];
        return s;
    endfunction

    function automatic logic [5:0] sel_of(input logic [15:0] w);
        logic [5:0] s;
        for (int i = 0; i < 6; i++) s[i] = w[13-i];
        return s;
    endfunction

    always begin
        @(posedge sys_clk or negedge sys_rst_n);
        if (!sys_rst_n) begin
            cyc = 0;
            rx_bits.delete();
            since = 0;
            last_clear = 0;
            m_word = '0;
        end else begin
            cyc++;
            if (cyc < HMAX) begin
                h_shcp[cyc] = bus.shcp;
                h_stcp[cyc] = bus.stcp;
                h_ds[cyc]   = bus.ds;
                h_oe[cyc]   = bus.oe;
            end
            m_fv  = 1'b0;
            m_err = 1'b0;
            k = cyc - D;
            if (k >= 1 && k < HMAX) begin
                sh_r = h_shcp[k] & ~((k > 1) ? h_shcp[k-1] : 1'b0);
                st_r = h_stcp[k] & ~((k > 1) ? h_stcp[k-1] : 1'b0);
                if (st_r) begin
                    m_fv       = 1'b1;
                    m_err      = (since != 16);
                    m_word     = last16();
                    last_clear = cyc;
                    since      = 0;
                end
                if (sh_r) begin
                    rx_bits.push_back(h_ds[k]);
                    since++;
                end
                m_oe_n = ~h_oe[k];
            end else begin
                m_oe_n = 1'b1;
            end
            #1;
            if (sys_rst_n) begin
                chk("m_word",        bus.word,        m_word);
                chk("m_sel",         bus.sel,         sel_of(m_word));
                chk("m_seg",         bus.seg,         seg_of(m_word));
                chk("m_frame_valid", bus.frame_valid, m_fv);
                chk("m_frame_err",   bus.frame_err,   m_err);
                chk("m_link_lost",   bus.link_lost,   ((cyc - last_clear) >= TMO));
                chk("m_out_en",      bus.out_en,      m_oe_n);
                fv_seen  += int'(bus.frame_valid);
                err_seen += int'(bus.frame_err);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, total=%0d", total);
        $fatal(1);
    end

    task automatic shift_bit(input logic b, input logic with_latch);
        @(negedge sys_clk); bus.ds = b; bus.shcp = 1'b0; bus.stcp = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk); bus.shcp = 1'b1; if (with_latch) bus.stcp = 1'b1;
        @(negedge sys_clk); bus.stcp = 1'b0;
    endtask

    task automatic send(input logic [15:0] w, input int n);
        for (int t = 0; t < n; t++) shift_bit(w[t], 1'b0);
    endtask

    task automatic latch();
        @(negedge sys_clk); bus.shcp = 1'b0; bus.stcp = 1'b1;
        @(negedge sys_clk);
        @(negedge sys_clk); bus.stcp = 1'b0;
        repeat (4) @(negedge sys_clk);
    endtask

    task automatic frame_check(input string nm, input logic [15:0] w,
                               input int fv0, input int err0, input int dfv, input int derr);
        chk({nm, "_word"}, bus.word, w);
        chk({nm, "_nfv"},  fv_seen - fv0, dfv);
        chk({nm, "_nerr"}, err_seen - err0, derr);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_word"}, bus.word, 16'h0);
        chk({nm, "_sel"},  bus.sel, 6'h0);
        chk({nm, "_seg"},  bus.seg, 8'h0);
        chk({nm, "_oen"},  bus.out_en, 1'b0);
        chk({nm, "_fv"},   bus.frame_valid, 1'b0);
        chk({nm, "_err"},  bus.frame_err, 1'b0);
        chk({nm, "_lost"}, bus.link_lost, 1'b0);
    endtask

    int fv0, err0;

    initial begin
        bus.shcp = 1'b0; bus.stcp = 1'b0; bus.ds = 1'b0; bus.oe = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk_reset_outputs("reset");
        sys_rst_n = 1'b1;

        // Link timeout from reset release.
        for (int g = 0; g < HMAX && cyc < TMO - 1; g++) begin @(posedge sys_clk); #2; end
        chk("lost_at_99", bus.link_lost, 1'b0);
        @(posedge sys_clk); #2;
        chk("lost_at_100", bus.link_lost, 1'b1);

        fv0 = fv_seen; err0 = err_seen;
        send(16'h2003, 16); latch();
        frame_check("f1", 16'h2003, fv0, err0, 1, 0);
        chk("f1_sel", bus.sel, 6'b000001);
        chk("f1_seg", bus.seg, 8'hC0);
        chk("f1_lost", bus.link_lost, 1'b0);

        fv0 = fv_seen; err0 = err_seen;
        send(16'h1F99, 16); latch();
        chk("b2b1_sel", bus.sel, 6'b111110);
        chk("b2b1_seg", bus.seg, 8'h99);
        send(16'h00FF, 16); latch();
        frame_check("b2b2", 16'h00FF, fv0, err0, 2, 0);
        chk("b2b2_sel", bus.sel, 6'b000000);
        chk("b2b2_seg", bus.seg, 8'hFF);

        @(negedge sys_clk); bus.oe = 1'b1;
        repeat (6) @(negedge sys_clk);
        chk("oe_off", bus.out_en, 1'b0);
        bus.oe = 1'b0;
        repeat (6) @(negedge sys_clk);
        chk("oe_on", bus.out_en, 1'b1);

        fv0 = fv_seen; err0 = err_seen;
        send(16'hA5A5, 15); latch();
        frame_check("short15", 16'h4B4A, fv0, err0, 1, 1);

        fv0 = fv_seen; err0 = err_seen;
        send(16'h1234, 16);
        shift_bit(1'b1, 1'b0); shift_bit(1'b1, 1'b0);
        shift_bit(1'b0, 1'b0); shift_bit(1'b0, 1'b0);
        latch();
        frame_check("over20", 16'h3123, fv0, err0, 1, 1);
        fv0 = fv_seen; err0 = err_seen;
        send(16'h2003, 16); latch();
        frame_check("clean_after_over", 16'h2003, fv0, err0, 1, 0);

        fv0 = fv_seen; err0 = err_seen;
        send(16'h5A3C, 16);
        shift_bit(1'b1, 1'b1);
        send(16'h1111, 15);
        frame_check("simul", 16'h5A3C, fv0, err0, 1, 0);
        fv0 = fv_seen; err0 = err_seen;
        latch();
        frame_check("simul_next", 16'h2223, fv0, err0, 1, 0);

        send(16'hFFFF, 8);
        @(negedge sys_clk); bus.shcp = 1'b0; bus.ds = 1'b0;
        sys_rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        fv0 = fv_seen; err0 = err_seen;
        send(16'h2003, 16); latch();
        frame_check("after_reset", 16'h2003, fv0, err0, 1, 0);

        repeat (4) @(negedge sys_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
